dma_burst_splitter: RTL and testbench

Splits one DMA transfer request (start address, byte count) into a sequence of AXI4 INCR burst commands. Each burst is at most MAX_BEATS beats long and never crosses a 4 KB boundary. It sits between the DMA channel control/register block and the AXI4 read/write address-channel drivers. Each emitted command carries the address and AWLEN/ARLEN value for one burst, so a downstream address/beat counter can load the address and advance it by the burst size.

---
 rtl/dma_pkg.sv | 20 ++
 rtl/dma_burst_splitter_len_calc.sv | 35 +++
 rtl/dma_burst_splitter.sv | 124 ++++++++++++
 tb/tb_dma_burst_splitter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst splitter.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } dma_split_state_e;

    localparam int AXI_4KB       = 4096;
    localparam int AXI_LEN_W     = 8;
    // 256 beats needs 9 bits, the widest burst we can ever emit
    localparam int BURST_BEATS_W = 9;

    function automatic int sh_of(input int data_bytes);
        return $clog2(data_bytes);
    endfunction

endpackage

// File: rtl/dma_burst_splitter_len_calc.sv
// Combinational burst sizing: min(remaining beats, beats to 4 KB edge, MAX_BEATS).
module burst_len_calc
    import dma_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int MAX_BEATS  = 256,
    parameter int BEATS_W    = 22
) (
    input  logic [11:0]              addr_lo_i,
    input  logic [BEATS_W-1:0]       rem_beats_i,
    output logic [BURST_BEATS_W-1:0] burst_beats_o
);

    localparam int SH = sh_of(DATA_BYTES);
    // Compare in a width that holds both 4096 and the full remaining count
    localparam int CW = (BEATS_W > 13) ? BEATS_W : 13;

    logic [12:0]   room;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] to_4k;
    logic [CW-1:0] bb;

    assign room  = 13'(AXI_4KB) - {1'b0, addr_lo_i};
    assign to_4k = CW'(room >> SH);
    assign rem_w = CW'(rem_beats_i);

    always_comb begin
        bb = CW'(MAX_BEATS);
        if (to_4k < bb) bb = to_4k;
        if (rem_w < bb) bb = rem_w;
    end

    assign burst_beats_o = BURST_BEATS_W'(bb);

endmodule

// File: rtl/dma_burst_splitter.sv
// Splits a DMA (address, byte count) request into AXI4 INCR burst commands
// that respect MAX_BEATS and never cross a 4 KB boundary.
module dma_burst_splitter
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 24,
    parameter int DATA_BYTES = 4,
    parameter int MAX_BEATS  = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_bytes,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [AXI_LEN_W-1:0]  cmd_len,
    output logic                  cmd_last,
    output logic                  busy,
    output logic                  done
);

    localparam int SH      = sh_of(DATA_BYTES);
    localparam int BEATS_W = LEN_WIDTH - SH;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

    dma_split_state_e           state_q;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [BEATS_W-1:0]         rem_q, rem_d;
    logic [BEATS_W-1:0]         req_beats;
    logic [BURST_BEATS_W-1:0]   bb_q, calc_bb;
    logic [ADDR_WIDTH-1:0]      cmd_addr_q;
    logic [AXI_LEN_W-1:0]       cmd_len_q;
    logic                       cmd_last_q, cmd_valid_q;
    logic                       req_ready_q, busy_q, done_q;

    assign req_beats = BEATS_W'(req_bytes >> SH);
    // Address wraps silently modulo 2^ADDR_WIDTH
    assign addr_d    = addr_q + (ADDR_WIDTH'(bb_q) << SH);
    assign rem_d     = rem_q - BEATS_W'(bb_q);

    burst_len_calc #(
        .DATA_BYTES (DATA_BYTES),
        .MAX_BEATS  (MAX_BEATS),
        .BEATS_W    (BEATS_W)
    ) u_len_calc (
        .addr_lo_i     (addr_q[11:0]),
        .rem_beats_i   (rem_q),
        .burst_beats_o (calc_bb)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            bb_q        <= '0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_last_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr & ALIGN_MASK;
                        rem_q       <= req_beats;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_beats == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    bb_q        <= calc_bb;
                    cmd_addr_q  <= addr_q;
                    cmd_len_q   <= AXI_LEN_W'(calc_bb - 1'b1);
                    cmd_last_q  <= (BEATS_W'(calc_bb) == rem_q);
                    cmd_valid_q <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        addr_q      <= addr_d;
                        rem_q       <= rem_d;
                        cmd_valid_q <= 1'b0;
                        if (cmd_last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_last  = cmd_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Bench for dma_burst_splitter: directed scenarios plus random requests checked against a burst-list model.
module tb_dma_burst_splitter;

    localparam int AW = 32;
    localparam int LW = 24;
    localparam int DB = 4;
    localparam int MB = 256;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_bytes;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          cmd_last, busy, done;

    int tests = 0;
    int fails = 0;

    longint q_addr[$];
    int     q_len[$];
    bit     q_last[$];

    always #5 clk = ~clk;

    dma_burst_splitter #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .DATA_BYTES (DB),
        .MAX_BEATS  (MB)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_bytes (req_bytes),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_last  (cmd_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected burst list from plain arithmetic on the request
    function automatic void build_model(input logic [31:0] a, input logic [23:0] b);
        longint addr = longint'(a) & 64'hFFFF_FFFC;
        longint rem  = longint'(b) / 4;
        longint room, n;
        q_addr.delete();
        q_len.delete();
        q_last.delete();
        while (rem > 0) begin
            room = (4096 - (addr % 4096)) / 4;
            n = rem;
            if (room < n) n = room;
            if (MB < n) n = MB;
            q_addr.push_back(addr);
            q_len.push_back(int'(n - 1));
            rem -= n;
            q_last.push_back(rem == 0);
            addr = (addr + n * 4) % 64'h1_0000_0000;
        end
    endfunction

    task automatic run_req(input logic [31:0] a, input logic [23:0] b,
                           input int stall_min, input int stall_max, input bit poke);
        int stalls;
        build_model(a, b);
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_bytes = b;
        tick();
        req_valid = 1'b0;
        if (q_addr.size() == 0) begin
            chk("zero_done", done, 1);
            chk("zero_noval", cmd_valid, 0);
            tick();
            chk("zero_done_drop", done, 0);
            chk("zero_ready", req_ready, 1);
            chk("zero_noval2", cmd_valid, 0);
            return;
        end
        chk("calc_busy", busy, 1);
        chk("calc_noval", cmd_valid, 0);
        chk("calc_noready", req_ready, 0);
        foreach (q_addr[i]) begin
            tick();
            chk("issue_valid", cmd_valid, 1);
            chk("cmd_addr", cmd_addr, q_addr[i]);
            chk("cmd_len", cmd_len, q_len[i]);
            chk("cmd_last", cmd_last, q_last[i]);
            stalls = $urandom_range(stall_max, stall_min);
            if (poke) req_valid = 1'b1;
            for (int s = 0; s < stalls; s++) begin
                tick();
                chk("stall_valid", cmd_valid, 1);
                chk("stall_addr", cmd_addr, q_addr[i]);
                chk("stall_len", cmd_len, q_len[i]);
                chk("stall_last", cmd_last, q_last[i]);
                chk("stall_noready", req_ready, 0);
                chk("stall_busy", busy, 1);
            end
            req_valid = 1'b0;
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            chk("post_hs_noval", cmd_valid, 0);
            chk("post_hs_done", done, q_last[i]);
        end
        tick();
        chk("end_done_drop", done, 0);
        chk("end_ready", req_ready, 1);
        chk("end_busy", busy, 0);
    endtask

    logic [31:0] ra;
    logic [23:0] rb;

    initial begin
        resetn    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_bytes = '0;
        cmd_ready = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", cmd_last, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_len", cmd_len, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        run_req(32'h0000_1000, 24'd64, 0, 0, 1'b0);
        run_req(32'h0000_0FF0, 24'd64, 0, 1, 1'b0);
        run_req(32'h0000_0000, 24'd4096, 0, 0, 1'b0);
        run_req(32'h0000_3000, 24'd2048, 5, 5, 1'b1);
        run_req(32'h0000_0500, 24'd0, 0, 0, 1'b0);
        run_req(32'hFFFF_F800, 24'd4096, 0, 2, 1'b0);
        run_req(32'h0000_1003, 24'h43, 0, 0, 1'b0);
        run_req(32'h0000_0FFC, 24'd3, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = ($urandom & 32'hFFFF_F000) - 32'($urandom_range(0, 64) * 4);
                default: ra = $urandom & 32'h0003_FFFC;
            endcase
            if ($urandom_range(0, 3) == 0) rb = 24'($urandom_range(0, 20000));
            else                            rb = 24'($urandom_range(0, 1200));
            run_req(ra, rb, 0, $urandom_range(0, 2), 1'b0);
        end

        // Reset in the middle of the second burst of a three-burst transfer
        chk("mr_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = 32'h0;
        req_bytes = 24'd3072;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mr_first_valid", cmd_valid, 1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        chk("mr_second_valid", cmd_valid, 1);
        chk("mr_second_addr", cmd_addr, 32'h400);
        #2 resetn = 1'b0;
        #1;
        chk("mr_valid", cmd_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", req_ready, 1);
        chk("mr_done", done, 0);
        chk("mr_addr", cmd_addr, 0);
        chk("mr_len", cmd_len, 0);
        chk("mr_last", cmd_last, 0);
        tick();
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_no_done", done, 0);
            chk("mr_no_cmd", cmd_valid, 0);
        end
        run_req(32'h0000_2000, 24'd8, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
